// File: rtl/lmfe_pixel_feeder.sv
// lmfe_pixel_feeder: streams one raster-order frame from a synchronous frame SRAM
// into the LMFE Din/in_en port. busy back-pressure is absorbed by a 2-entry skid
// FIFO, so no pixel is lost or repeated.
module lmfe_pixel_feeder #(
    parameter int unsigned IMG_W = 128,
    parameter int unsigned IMG_H = 128,
    parameter int unsigned AW    = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] mem_a,
    output logic          mem_cen,
    input  logic [7:0]    mem_q,
    input  logic          busy,
    output logic          in_en,
    output logic [7:0]    Din,
    output logic          done
);

    // Counters are one bit wider than the address so the terminal count fits.
    localparam logic [AW:0] PIX_TOTAL = (AW+1)'(IMG_W * IMG_H);
    localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e        state_q;
    logic [AW:0]   rd_addr_q;
    logic [AW:0]   xfer_cnt_q;
    logic          done_q;

    // Skid FIFO: head_q is the registered Din, tail_q the second slot.
    logic [1:0]    fifo_cnt_q, fifo_cnt_d;
    logic [7:0]    head_q, head_d;
    logic [7:0]    tail_q, tail_d;
    logic          in_flight_q;
    logic [AW-1:0] last_a_q;

    logic          xfer;
    logic          push;
    logic          issue;
    logic [2:0]    occupancy;

    // A pixel moves whenever the FIFO holds one and the engine is not busy.
    assign xfer      = (fifo_cnt_q != 2'd0) && !busy;
    // SRAM data lands one cycle after the read was issued.
    assign push      = in_flight_q;
    // Slots committed = stored + in flight; a same-cycle transfer frees one.
    assign occupancy = {1'b0, fifo_cnt_q} + {2'b00, in_flight_q};
    assign issue     = (state_q == StRun) && (rd_addr_q < PIX_TOTAL) &&
                       (occupancy < (3'd2 + {2'b00, xfer}));

    assign mem_cen = !issue;
    // mem_a shows the live read address, otherwise the last issued one.
    assign mem_a   = issue ? rd_addr_q[AW-1:0] : last_a_q;
    assign in_en   = (fifo_cnt_q != 2'd0);
    assign Din     = head_q;
    assign done    = done_q;

    // FIFO next state: push from SRAM, pop on transfer, both may coincide.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, xfer};
        case (fifo_cnt_q)
            2'd0: begin
                if (push) head_d = mem_q;
            end
            2'd1: begin
                if (push && xfer) begin
                    head_d = mem_q;
                end else if (push) begin
                    tail_d = mem_q;
                end
            end
            default: begin
                if (xfer) begin
                    head_d = tail_q;
                    if (push) tail_d = mem_q;
                end
            end
        endcase
    end

    // FIFO storage, read-in-flight flag and held SRAM address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_cnt_q  <= 2'd0;
            head_q      <= 8'h00;
            tail_q      <= 8'h00;
            in_flight_q <= 1'b0;
            last_a_q    <= '0;
        end else begin
            fifo_cnt_q  <= fifo_cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_flight_q <= issue;
            if (issue) last_a_q <= rd_addr_q[AW-1:0];
        end
    end

    // Frame sequencer: read address, transfer count, state and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            rd_addr_q  <= '0;
            xfer_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (issue) rd_addr_q <= rd_addr_q + CNT_ONE;
            if (xfer) xfer_cnt_q <= xfer_cnt_q + CNT_ONE;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StRun;
                        rd_addr_q  <= '0;
                        xfer_cnt_q <= '0;
                    end
                end
                StRun: begin
                    if (rd_addr_q == PIX_TOTAL) state_q <= StDrain;
                end
                StDrain: begin
                    if (xfer && ((xfer_cnt_q + CNT_ONE) == PIX_TOTAL)) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lmfe_pixel_feeder.sv
// Bench for lmfe_pixel_feeder: a 4x4 frame with mem[i] = A0+i, directed scenarios
// plus randomized busy/start, all checked against a frame-level reference model.
module tb_lmfe_pixel_feeder;
    localparam int unsigned IMG_W = 4;
    localparam int unsigned IMG_H = 4;
    localparam int unsigned AW    = 4;
    localparam int TOTAL = IMG_W * IMG_H;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic [AW-1:0] mem_a;
    logic          mem_cen;
    logic [7:0]    mem_q = 8'h00;
    logic          in_en;
    logic [7:0]    Din;
    logic          done;

    logic [7:0] mem [TOTAL];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lmfe_pixel_feeder #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (AW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mem_a   (mem_a),
        .mem_cen (mem_cen),
        .mem_q   (mem_q),
        .busy    (busy),
        .in_en   (in_en),
        .Din     (Din),
        .done    (done)
    );

    // Synchronous frame SRAM: data valid the cycle after a read.
    always @(posedge clk) begin
        if (!mem_cen) mem_q <= mem[mem_a];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state: frame-level counts only.
    bit m_active   = 1'b0;
    int m_reads    = 0;
    int m_xfer     = 0;
    int m_k        = 0;
    bit m_done_due = 1'b0;
    int done_cnt   = 0;
    int xfer_total = 0;
    int reads_total = 0;
    bit prev_in_en = 1'b0;
    bit prev_busy  = 1'b0;
    logic [7:0] prev_din = 8'h00;

    // Compare process: sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        bit xfer_now;
        bit start_ok;
        bit due_next;
        if (!reset) begin
            check("rst_in_en", 32'(in_en), 32'd0);
            check("rst_mem_cen", 32'(mem_cen), 32'd1);
            check("rst_mem_a", 32'(mem_a), 32'd0);
            check("rst_din", 32'(Din), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            m_active   = 1'b0;
            m_reads    = 0;
            m_xfer     = 0;
            m_done_due = 1'b0;
            prev_in_en = 1'b0;
            prev_busy  = 1'b0;
        end else begin
            xfer_now = in_en && !busy;
            start_ok = start && !m_active;
            due_next = 1'b0;
            if (!mem_cen) reads_total++;
            if (!m_active) begin
                check("idle_mem_cen", 32'(mem_cen), 32'd1);
                check("idle_in_en", 32'(in_en), 32'd0);
            end else begin
                m_k++;
                // First pixel appears on the third sample after start is taken.
                if (m_k <= 2) check("latency_low", 32'(in_en), 32'd0);
                else if (m_k == 3) check("latency_rise", 32'(in_en), 32'd1);
                if (prev_in_en && prev_busy) begin
                    check("hold_in_en", 32'(in_en), 32'd1);
                    check("hold_din", 32'(Din), 32'(prev_din));
                end
                if (!mem_cen) begin
                    check("read_addr", 32'(mem_a), 32'(m_reads));
                    check("read_in_range", 32'(m_reads < TOTAL), 32'd1);
                    m_reads++;
                    check("read_outstanding", 32'((m_reads - m_xfer - int'(xfer_now)) <= 2), 32'd1);
                end
                if (xfer_now) begin
                    check("pixel", 32'(Din), (32'hA0 + 32'(m_xfer)) & 32'hFF);
                    m_xfer++;
                    xfer_total++;
                    if (m_xfer == TOTAL) due_next = 1'b1;
                end
            end
            check("done", 32'(done), 32'(m_done_due));
            if (m_done_due) begin
                m_active = 1'b0;
                done_cnt++;
            end
            m_done_due = due_next;
            if (start_ok) begin
                m_active = 1'b1;
                m_reads  = 0;
                m_xfer   = 0;
                m_k      = 0;
            end
            prev_in_en = in_en;
            prev_busy  = busy;
            prev_din   = Din;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic wait_pix(input string name, input logic [7:0] v, input int budget);
        int n = 0;
        while (!(in_en && Din == v) && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(in_en && Din == v), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int x0, d0, r0, n, first, run, maxrun, done_at;
        logic [7:0] first_pix, last_pix;
        for (int i = 0; i < TOTAL; i++) mem[i] = 8'(8'hA0 + i);
        reset = 1'b0;
        start = 1'b0;
        busy  = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        check("post_reset_in_en", 32'(in_en), 32'd0);
        check("post_reset_din", 32'(Din), 32'd0);

        // 1: free-running frame.
        x0 = xfer_total; d0 = done_cnt;
        first = 0; run = 0; maxrun = 0; done_at = 0;
        first_pix = 8'h00; last_pix = 8'h00;
        pulse_start();
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (in_en) begin
                if (first == 0) begin
                    first = i;
                    first_pix = Din;
                end
                run++;
                last_pix = Din;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (done && done_at == 0) done_at = i;
        end
        tick();
        check("t1_first_rise", 32'(first), 32'd3);
        check("t1_run_length", 32'(maxrun), 32'd16);
        check("t1_first_pix", 32'(first_pix), 32'hA0);
        check("t1_last_pix", 32'(last_pix), 32'hAF);
        check("t1_done_at", 32'(done_at), 32'd19);
        check("t1_xfers", 32'(xfer_total - x0), 32'd16);
        check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

        // 2: five busy cycles while A5 is at the head.
        x0 = xfer_total;
        pulse_start();
        wait_pix("t2_reach_a5", 8'hA5, 40);
        busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_din", 32'(Din), 32'hA5);
            check("t2_hold_en", 32'(in_en), 32'd1);
            if (i >= 1) check("t2_cen_full", 32'(mem_cen), 32'd1);
            tick();
        end
        busy = 1'b0;
        check("t2_resume_a5", 32'(Din), 32'hA5);
        tick();
        check("t2_next_a6", 32'(Din), 32'hA6);
        wait_done("t2_done", 60);
        check("t2_xfers", 32'(xfer_total - x0), 32'd16);

        // 3: busy toggling every cycle.
        x0 = xfer_total; d0 = done_cnt;
        busy = 1'b1;
        pulse_start();
        n = 0;
        while (done_cnt == d0 && n < 100) begin
            busy = ~busy;
            tick();
            n++;
        end
        busy = 1'b0;
        repeat (5) tick();
        check("t3_xfers", 32'(xfer_total - x0), 32'd16);
        check("t3_done_once", 32'(done_cnt - d0), 32'd1);

        // 4: reset right after the A7 transfer, then a fresh frame.
        d0 = done_cnt;
        pulse_start();
        wait_pix("t4_reach_a7", 8'hA7, 40);
        tick();
        reset = 1'b0;
        #1;
        check("t4_rst_in_en", 32'(in_en), 32'd0);
        check("t4_rst_cen", 32'(mem_cen), 32'd1);
        check("t4_rst_a", 32'(mem_a), 32'd0);
        check("t4_rst_din", 32'(Din), 32'd0);
        check("t4_rst_done", 32'(done), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);
        pulse_start();
        wait_pix("t4_restart_a0", 8'hA0, 10);
        wait_done("t4_done", 60);

        // 5: start in RUN and in the DONE cycle are ignored.
        x0 = xfer_total; d0 = done_cnt;
        pulse_start();
        repeat (6) tick();
        pulse_start();
        n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        check("t5_saw_done", 32'(done), 32'd1);
        pulse_start();
        repeat (8) tick();
        check("t5_xfers", 32'(xfer_total - x0), 32'd16);
        check("t5_done_once", 32'(done_cnt - d0), 32'd1);
        check("t5_idle_in_en", 32'(in_en), 32'd0);
        check("t5_idle_cen", 32'(mem_cen), 32'd1);
        x0 = xfer_total;
        pulse_start();
        wait_done("t5_second_frame", 60);
        check("t5_second_xfers", 32'(xfer_total - x0), 32'd16);

        // 6: busy held from before start for ten cycles.
        busy = 1'b1;
        tick();
        r0 = reads_total;
        pulse_start();
        repeat (9) tick();
        check("t6_reads", 32'(reads_total - r0), 32'd2);
        check("t6_din", 32'(Din), 32'hA0);
        check("t6_in_en", 32'(in_en), 32'd1);
        busy = 1'b0;
        tick();
        check("t6_a1", 32'(Din), 32'hA1);
        tick();
        check("t6_a2", 32'(Din), 32'hA2);
        wait_done("t6_done", 60);

        // Randomized busy density with stray start pulses.
        for (int f = 0; f < 8; f++) begin
            int pct;
            pct = (f % 4) * 25;
            x0 = xfer_total; d0 = done_cnt;
            pulse_start();
            n = 0;
            while (done_cnt == d0 && n < 400) begin
                busy  = ($urandom_range(0, 99) < pct);
                start = ($urandom_range(0, 19) == 0);
                tick();
                n++;
            end
            start = 1'b0;
            busy  = 1'b0;
            repeat (3) tick();
            check("rnd_done_once", 32'(done_cnt - d0), 32'd1);
            check("rnd_xfers", 32'(xfer_total - x0), 32'd16);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
